i2c_slave_regif: RTL and testbench

- Second-generation I2C slave. Replaces the SCL-clocked slave with a design fully synchronous to the system clock: SCL and SDA are oversampled, and all state runs on `clk`.
- Parametrised in address width, data width and number of byte registers.
- Adds multi-byte bursts with an auto-incrementing index, repeated-START handling and a receive back-pressure NACK.
- Sits between the open-drain pad logic and the local register/host logic on the slave side of the I2C test system.

---
 rtl/i2c_slave_regif.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// I2C slave with a byte-register interface, fully synchronous to clk.
// SCL/SDA are oversampled; supports bursts, repeated START and receive back-pressure.
module i2c_slave_regif #(
  parameter int                  ADDR_LEN    = 7,
  parameter int                  DATA_LEN    = 8,
  parameter int                  NUM_REGS    = 4,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'b1011011,
  parameter int                  SYNC_STAGES = 2,
  localparam int                 IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scl_in,
  input  logic                         sda_in,
  output logic                         sda_oe,
  input  logic [NUM_REGS*DATA_LEN-1:0] tx_data,
  input  logic                         rx_ready,
  output logic [DATA_LEN-1:0]          rx_data,
  output logic [IDX_W-1:0]             rx_index,
  output logic                         rx_valid,
  output logic                         busy,
  output logic                         rd_nack
);

  localparam int CNT_MAX = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SR_W    = CNT_MAX;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_WRITE_ACK = 3'd4;
  localparam logic [2:0] ST_READ      = 3'd5;
  localparam logic [2:0] ST_READ_ACK  = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SR_W-1:0]     rx_shift_q, rx_shift_d, rx_shift_in;
  logic [DATA_LEN-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]    index_q, index_d, index_inc;
  logic                rw_q, rw_d, match_q, match_d, rx_ok_q, rx_ok_d;
  logic                sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic                rx_valid_q, rx_valid_d, rd_nack_q, rd_nack_d;
  logic [DATA_LEN-1:0] rx_data_q, rx_data_d;
  logic [IDX_W-1:0]    rx_index_q, rx_index_d;
  logic                addr_hit;

  logic [DATA_LEN-1:0] tx_bytes [NUM_REGS];
  logic [DATA_LEN-1:0] tx_sel;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_tx
    assign tx_bytes[g] = tx_data[g*DATA_LEN +: DATA_LEN];
  end
  assign tx_sel = tx_bytes[index_q];

  // Synchronisers reset to 1 so the bus looks idle and no false START is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  assign start_det = scl_s & ~sda_s & sda_dly_q;
  assign stop_det  = scl_s & sda_s & ~sda_dly_q;

  assign index_inc   = (index_q == IDX_W'(NUM_REGS - 1)) ? '0 : index_q + 1'b1;
  assign rx_shift_in = {rx_shift_q[SR_W-2:0], sda_s};
  assign addr_hit    = (rx_shift_in[ADDR_LEN:1] == SLAVE_ADDR);

  always_comb begin
    // NOTE: every next-state signal gets a default here, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    index_d    = index_q;
    rw_d       = rw_q;
    match_d    = match_q;
    rx_ok_d    = rx_ok_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_index_d = rx_index_q;
    rx_valid_d = 1'b0;
    rd_nack_d  = 1'b0;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = CNT_W'(ADDR_LEN + 1);
      index_d  = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            rx_shift_d = rx_shift_in;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              match_d = addr_hit;
              rw_d    = rx_shift_in[0];
              if (addr_hit) busy_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == '0) begin
            state_d  = match_q ? ST_ADDR_ACK : ST_WAIT_STOP;
            sda_oe_d = match_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = CNT_W'(DATA_LEN);
            if (rw_q) begin
              state_d    = ST_READ;
              tx_shift_d = tx_sel;
              sda_oe_d   = ~tx_sel[DATA_LEN-1];
            end else begin
              state_d  = ST_WRITE;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            rx_shift_d = rx_shift_in;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              rx_ok_d = rx_ready;
              if (rx_ready) begin
                rx_data_d  = rx_shift_in[DATA_LEN-1:0];
                rx_index_d = index_q;
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && cnt_q == '0) begin
            state_d  = ST_WRITE_ACK;
            sda_oe_d = rx_ok_q;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (rx_ok_q) begin
              index_d = index_inc;
              cnt_d   = CNT_W'(DATA_LEN);
              state_d = ST_WRITE;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_READ: begin
          if (scl_rise) begin
            cnt_d = cnt_q - 1'b1;
          end else if (scl_fall) begin
            if (cnt_q != '0) begin
              tx_shift_d = {tx_shift_q[DATA_LEN-2:0], 1'b0};
              sda_oe_d   = ~tx_shift_d[DATA_LEN-1];
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_READ_ACK;
            end
          end
        end
        ST_READ_ACK: begin
          // Only an ACKed slot reaches its closing fall; a NACK leaves at the rise.
          if (scl_rise) begin
            if (sda_s) begin
              rd_nack_d = 1'b1;
              state_d   = ST_WAIT_STOP;
            end else begin
              index_d = index_inc;
            end
          end else if (scl_fall) begin
            cnt_d      = CNT_W'(DATA_LEN);
            tx_shift_d = tx_sel;
            sda_oe_d   = ~tx_sel[DATA_LEN-1];
            state_d    = ST_READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      index_q    <= '0;
      rw_q       <= 1'b0;
      match_q    <= 1'b0;
      rx_ok_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_index_q <= '0;
      rx_valid_q <= 1'b0;
      rd_nack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      index_q    <= index_d;
      rw_q       <= rw_d;
      match_q    <= match_d;
      rx_ok_q    <= rx_ok_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_index_q <= rx_index_d;
      rx_valid_q <= rx_valid_d;
      rd_nack_q  <= rd_nack_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_index = rx_index_q;
  assign rx_valid = rx_valid_q;
  assign rd_nack  = rd_nack_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: a bit-banged master on an open-drain SDA model.
module tb_i2c_slave_regif;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        rx_ready = 1'b1;
  logic [31:0] tx_data = 32'h44332211;
  wire         sda_bus;
  wire         sda_oe;
  wire  [7:0]  rx_data;
  wire  [1:0]  rx_index;
  wire         rx_valid, busy, rd_nack;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regif dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_index (rx_index),
    .rx_valid (rx_valid),
    .busy     (busy),
    .rd_nack  (rd_nack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bus monitor: counts events so tests can compare before/after snapshots.
  int         rxv_cnt = 0, nack_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  int         busy_low_cnt = 0, oe_hi_change = 0;
  logic       watch_busy = 1'b0;
  logic       oe_prev = 1'b0;
  logic [7:0] rxd_q[$];
  logic [1:0] rxi_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rxd_q.push_back(rx_data);
      rxi_q.push_back(rx_index);
    end
    if (rd_nack) nack_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (watch_busy && !busy) busy_low_cnt++;
    if (rst_n && scl_m && sda_oe !== oe_prev) oe_hi_change++;
    oe_prev = sda_oe;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic rd);
    tick(4); sda_m = b;
    tick(4); scl_m = 1'b1;
    tick(4); @(negedge clk); rd = sda_bus;
    tick(4); scl_m = 1'b0;
  endtask

  task automatic start_cond();
    tick(4); sda_m = 1'b0;
    tick(4); scl_m = 1'b0;
  endtask

  task automatic rep_start();
    tick(4); sda_m = 1'b1;
    tick(4); scl_m = 1'b1;
    tick(4); sda_m = 1'b0;
    tick(4); scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    tick(4); sda_m = 1'b0;
    tick(4); scl_m = 1'b1;
    tick(4); sda_m = 1'b1;
    tick(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic rd;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], rd);
    bit_cycle(1'b1, rd);
    acked = ~rd;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic rd;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, rd);
      b[i] = rd;
    end
    bit_cycle(~ack, rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %0b expected 0", sda_oe); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (rd_nack !== 1'b0) begin errors++; $display("FAIL reset_rd_nack: got %0b expected 0", rd_nack); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
    checks++; if (rx_index !== 2'd0) begin errors++; $display("FAIL reset_rx_index: got %0d expected 0", rx_index); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_write();
    logic a;
    int   rv0 = rxv_cnt;
    start_cond();
    write_byte(8'hB6, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %0b expected 1", a); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %0b expected 1", busy); end
    write_byte(8'hA5, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL write_data0_ack: got %0b expected 1", a); end
    write_byte(8'h3C, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL write_data1_ack: got %0b expected 1", a); end
    stop_cond();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %0b expected 0", busy); end
    checks++; if (rxv_cnt - rv0 != 2) begin errors++; $display("FAIL write_rx_valid_count: got %0d expected 2", rxv_cnt - rv0); end
    if (rxv_cnt - rv0 >= 2) begin
      checks++; if (rxd_q[rv0] !== 8'hA5) begin errors++; $display("FAIL write_rx_data0: got %0h expected a5", rxd_q[rv0]); end
      checks++; if (rxi_q[rv0] !== 2'd0) begin errors++; $display("FAIL write_rx_index0: got %0d expected 0", rxi_q[rv0]); end
      checks++; if (rxd_q[rv0+1] !== 8'h3C) begin errors++; $display("FAIL write_rx_data1: got %0h expected 3c", rxd_q[rv0+1]); end
      checks++; if (rxi_q[rv0+1] !== 2'd1) begin errors++; $display("FAIL write_rx_index1: got %0d expected 1", rxi_q[rv0+1]); end
    end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    int   oe0 = oe_cnt, b0 = busy_cnt, rv0 = rxv_cnt;
    start_cond();
    write_byte(8'hB4, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack: got %0b expected 0", a); end
    write_byte(8'hFF, a);
    stop_cond();
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL mismatch_sda_oe_cycles: got %0d expected 0", oe_cnt - oe0); end
    checks++; if (busy_cnt != b0) begin errors++; $display("FAIL mismatch_busy_cycles: got %0d expected 0", busy_cnt - b0); end
    checks++; if (rxv_cnt != rv0) begin errors++; $display("FAIL mismatch_rx_valid: got %0d expected 0", rxv_cnt - rv0); end
  endtask

  task automatic test_read_burst();
    logic       a;
    logic [7:0] d;
    logic [7:0] exp_rd [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    int         n0 = nack_cnt;
    start_cond();
    write_byte(8'hB7, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %0b expected 1", a); end
    for (int k = 0; k < 6; k++) begin
      read_byte(k < 5, d);
      checks++; if (d !== exp_rd[k]) begin errors++; $display("FAIL read_byte%0d: got %0h expected %0h", k, d, exp_rd[k]); end
    end
    stop_cond();
    checks++; if (nack_cnt - n0 != 1) begin errors++; $display("FAIL read_rd_nack_count: got %0d expected 1", nack_cnt - n0); end
  endtask

  task automatic test_rx_backpressure();
    logic a;
    int   rv0 = rxv_cnt, oe0;
    rx_ready = 1'b0;
    start_cond();
    write_byte(8'hB6, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bp_addr_ack: got %0b expected 1", a); end
    write_byte(8'h7E, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL bp_data_nack: got %0b expected 0", a); end
    oe0 = oe_cnt;
    write_byte(8'h00, a);
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL bp_wait_stop_quiet: got %0d expected 0", oe_cnt - oe0); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_until_stop: got %0b expected 1", busy); end
    stop_cond();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after_stop: got %0b expected 0", busy); end
    checks++; if (rxv_cnt != rv0) begin errors++; $display("FAIL bp_rx_valid: got %0d expected 0", rxv_cnt - rv0); end
    rx_ready = 1'b1;
  endtask

  task automatic test_repeated_start();
    logic       a;
    logic [7:0] d;
    int         bl0;
    start_cond();
    write_byte(8'hB6, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_addr_w_ack: got %0b expected 1", a); end
    write_byte(8'h99, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_data_ack: got %0b expected 1", a); end
    bl0 = busy_low_cnt;
    watch_busy = 1'b1;
    rep_start();
    write_byte(8'hB7, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_addr_r_ack: got %0b expected 1", a); end
    read_byte(1'b0, d);
    watch_busy = 1'b0;
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL rs_read_byte: got %0h expected 11", d); end
    checks++; if (busy_low_cnt != bl0) begin errors++; $display("FAIL rs_busy_held: got %0d low cycles expected 0", busy_low_cnt - bl0); end
    checks++; if (rx_data !== 8'h99) begin errors++; $display("FAIL rs_rx_data: got %0h expected 99", rx_data); end
    stop_cond();
  endtask

  task automatic test_reset_mid_transfer();
    logic a;
    int   oe0;
    start_cond();
    write_byte(8'hB7, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rst_addr_ack: got %0b expected 1", a); end
    tick(6);
    @(negedge clk);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_driving_zero: got %0b expected 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_async_release: got %0b expected 0", sda_oe); end
    tick(2);
    rst_n = 1'b1;
    tick(4);
    oe0 = oe_cnt;
    write_byte(8'hB6, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rst_no_start_ack: got %0b expected 0", a); end
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL rst_no_start_quiet: got %0d expected 0", oe_cnt - oe0); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_start_busy: got %0b expected 0", busy); end
    stop_cond();
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read_burst();
    test_rx_backpressure();
    test_repeated_start();
    test_reset_mid_transfer();
    checks++; if (oe_hi_change != 0) begin errors++; $display("FAIL sda_oe_stable_scl_high: got %0d changes expected 0", oe_hi_change); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
